// File: rtl/spi_slave_trx_char.sv
// ---------------------------------------------------------------------------
// spi_slave_trx_char
//
// Target-side SPI character transceiver. SCK, CS_N and MOSI are
// oversampled in the S_SYSCLK domain. The block shifts out one transmit
// character per character time while CS_N is low, and returns each received
// character with a one-cycle done strobe.
//
// Parameters
//   CHAR_LEN_MAX : widest character in bits (width of S_WCHAR / S_RCHAR).
//   SYNC_STAGES  : synchronizer depth on SCK, CS_N and MOSI (2 or 3).
//
// Ports
//   S_SYSCLK, S_RESETN       : clock, asynchronous active-low reset.
//   S_ENABLE                 : block enable. Low aborts and empties the
//                              holding register.
//   S_CPOL, S_CPHA, S_REV    : SPI mode and bit order (S_REV=1 -> MSB first).
//   S_CHAR_LEN               : character length - 1. Values 0..2 mean 4 bits.
//   S_SPI_SCK/CS_N/MOSI      : pins driven by the master.
//   S_SPI_MISO, _OE          : serial data out and pad output enable.
//   S_WCHAR/S_WVALID/S_WREADY: transmit holding register write handshake.
//   S_RCHAR, S_RCHAR_DONE    : received character and its update strobe.
//   S_UNDERRUN               : strobe when a character starts with an empty
//                              holding register (all ones are sent).
// ---------------------------------------------------------------------------
module spi_slave_trx_char #(
    parameter int CHAR_LEN_MAX = 16,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                    S_SYSCLK,
    input  logic                    S_RESETN,
    input  logic                    S_ENABLE,
    input  logic                    S_CPOL,
    input  logic                    S_CPHA,
    input  logic                    S_REV,
    input  logic [3:0]              S_CHAR_LEN,
    input  logic                    S_SPI_SCK,
    input  logic                    S_SPI_CS_N,
    input  logic                    S_SPI_MOSI,
    output logic                    S_SPI_MISO,
    output logic                    S_SPI_MISO_OE,
    input  logic [CHAR_LEN_MAX-1:0] S_WCHAR,
    input  logic                    S_WVALID,
    output logic                    S_WREADY,
    output logic [CHAR_LEN_MAX-1:0] S_RCHAR,
    output logic                    S_RCHAR_DONE,
    output logic                    S_UNDERRUN
);

    localparam int W = CHAR_LEN_MAX;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2
    } state_t;

    // Bit currently presented by the tx shift register.
    function automatic logic pick_bit(input logic [W-1:0] v, input logic rev,
                                      input logic [3:0] len_m1);
        return rev ? v[len_m1] : v[0];
    endfunction

    // Advance the tx shift register by one bit in the selected order.
    function automatic logic [W-1:0] tx_step(input logic [W-1:0] v, input logic rev);
        return rev ? (v << 1) : (v >> 1);
    endfunction

    // ---------------------------------------------------------------------
    // Input synchronizers and edge detection
    // ---------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sck_sync_q;
    logic [SYNC_STAGES-1:0] cs_sync_q;
    logic [SYNC_STAGES-1:0] mosi_sync_q;
    logic                   sck_d1_q;
    logic                   cs_d1_q;

    logic sck_s;
    logic cs_s;
    logic mosi_s;
    logic lead_edge;
    logic trail_edge;
    logic sample_edge;
    logic shift_edge;
    logic cs_fall;

    always_ff @(posedge S_SYSCLK or negedge S_RESETN) begin
        if (!S_RESETN) begin
            sck_sync_q  <= '0;
            cs_sync_q   <= '1;
            mosi_sync_q <= '0;
            sck_d1_q    <= 1'b0;
            cs_d1_q     <= 1'b1;
        end else begin
            sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], S_SPI_SCK};
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], S_SPI_CS_N};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], S_SPI_MOSI};
            sck_d1_q    <= sck_s;
            cs_d1_q     <= cs_s;
        end
    end

    assign sck_s  = sck_sync_q[SYNC_STAGES-1];
    assign cs_s   = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

    // Leading edge: SCK leaves its idle level; trailing edge: it returns.
    assign lead_edge   = (sck_d1_q == S_CPOL) && (sck_s != S_CPOL);
    assign trail_edge  = (sck_d1_q != S_CPOL) && (sck_s == S_CPOL);
    assign sample_edge = S_CPHA ? trail_edge : lead_edge;
    assign shift_edge  = S_CPHA ? lead_edge  : trail_edge;
    assign cs_fall     = cs_d1_q & ~cs_s;

    // ---------------------------------------------------------------------
    // State and datapath registers
    // ---------------------------------------------------------------------
    state_t         state_q,    state_d;
    logic [W-1:0]   tx_q,       tx_d;
    logic [W-1:0]   rx_q,       rx_d;
    logic [W-1:0]   hold_q,     hold_d;
    logic           full_q,     full_d;
    logic [W-1:0]   rchar_q,    rchar_d;
    logic           done_q,     done_d;
    logic           underrun_q, underrun_d;
    logic           miso_q,     miso_d;
    logic           wready_q,   wready_d;
    logic           shift_ok_q, shift_ok_d;
    logic [3:0]     cnt_q,      cnt_d;
    logic [3:0]     len_m1_q,   len_m1_d;
    logic           rev_q,      rev_d;

    logic [3:0]     cfg_len_m1;
    logic [W-1:0]   load_word;
    logic [W-1:0]   rx_ins;
    logic           accept;
    logic           abort;

    // Lengths below 4 bits are not supported on the wire; round them up.
    assign cfg_len_m1 = (S_CHAR_LEN < 4'd3) ? 4'd3 : S_CHAR_LEN;

    // An empty holding register at LOAD sends all ones.
    assign load_word = full_q ? hold_q : '1;

    // MSB first: shift left so the first bit ends at position len-1.
    // LSB first: insert at len-1 and shift right so the first bit ends at 0.
    // rx is cleared at LOAD, so bits above len-1 stay zero either way.
    assign rx_ins = rev_q ? {rx_q[W-2:0], mosi_s}
                          : ((rx_q >> 1) | ({{(W-1){1'b0}}, mosi_s} << len_m1_q));

    assign accept = S_WVALID & S_WREADY;
    assign abort  = ~S_ENABLE | cs_s;

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (S_ENABLE && cs_fall) state_d = ST_LOAD;
            ST_LOAD:  state_d = ST_SHIFT;
            ST_SHIFT: if (sample_edge && (cnt_q == 4'd0)) state_d = ST_LOAD;
            default:  state_d = ST_IDLE;
        endcase
        if (abort) state_d = ST_IDLE;
    end

    // Datapath next-state logic
    always_comb begin
        tx_d       = tx_q;
        rx_d       = rx_q;
        hold_d     = hold_q;
        full_d     = full_q;
        rchar_d    = rchar_q;
        done_d     = 1'b0;
        underrun_d = 1'b0;
        miso_d     = miso_q;
        shift_ok_d = shift_ok_q;
        cnt_d      = cnt_q;
        len_m1_d   = len_m1_q;
        rev_d      = rev_q;

        case (state_q)
            ST_IDLE: begin
                miso_d     = 1'b0;
                rx_d       = '0;
                cnt_d      = cfg_len_m1;
                shift_ok_d = 1'b0;
            end
            ST_LOAD: begin
                len_m1_d   = cfg_len_m1;
                rev_d      = S_REV;
                cnt_d      = cfg_len_m1;
                rx_d       = '0;
                full_d     = 1'b0;
                underrun_d = ~full_q;
                if (!S_CPHA) begin
                    // First bit goes out now, ahead of the first SCK edge.
                    miso_d     = pick_bit(load_word, S_REV, cfg_len_m1);
                    tx_d       = tx_step(load_word, S_REV);
                    shift_ok_d = 1'b0;
                end else begin
                    // First bit goes out on the first (leading) shift edge.
                    tx_d       = load_word;
                    shift_ok_d = 1'b1;
                end
            end
            ST_SHIFT: begin
                // shift_ok gates shift edges so that the one following the
                // last sample of a character cannot disturb the next one.
                if (shift_edge && shift_ok_q) begin
                    miso_d     = pick_bit(tx_q, rev_q, len_m1_q);
                    tx_d       = tx_step(tx_q, rev_q);
                    shift_ok_d = 1'b0;
                end
                if (sample_edge) begin
                    rx_d = rx_ins;
                    if (cnt_q == 4'd0) begin
                        rchar_d = rx_ins;
                        done_d  = 1'b1;
                    end else begin
                        cnt_d      = cnt_q - 4'd1;
                        shift_ok_d = 1'b1;
                    end
                end
            end
            default: begin
                miso_d = 1'b0;
            end
        endcase

        // A write in the same cycle as LOAD lands after LOAD took the old word.
        if (accept) begin
            hold_d = S_WCHAR;
            full_d = 1'b1;
        end

        // Partial characters are dropped without touching S_RCHAR.
        if (abort) begin
            rchar_d    = rchar_q;
            done_d     = 1'b0;
            rx_d       = '0;
            cnt_d      = cfg_len_m1;
            shift_ok_d = 1'b0;
        end
        if (!S_ENABLE) begin
            full_d = 1'b0;
        end

        wready_d = S_ENABLE & ~full_d;
    end

    always_ff @(posedge S_SYSCLK or negedge S_RESETN) begin
        if (!S_RESETN) begin
            state_q    <= ST_IDLE;
            tx_q       <= '0;
            rx_q       <= '0;
            hold_q     <= '0;
            full_q     <= 1'b0;
            rchar_q    <= '0;
            done_q     <= 1'b0;
            underrun_q <= 1'b0;
            miso_q     <= 1'b0;
            wready_q   <= 1'b0;
            shift_ok_q <= 1'b0;
            cnt_q      <= 4'd0;
            len_m1_q   <= 4'd3;
            rev_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            tx_q       <= tx_d;
            rx_q       <= rx_d;
            hold_q     <= hold_d;
            full_q     <= full_d;
            rchar_q    <= rchar_d;
            done_q     <= done_d;
            underrun_q <= underrun_d;
            miso_q     <= miso_d;
            wready_q   <= wready_d;
            shift_ok_q <= shift_ok_d;
            cnt_q      <= cnt_d;
            len_m1_q   <= len_m1_d;
            rev_q      <= rev_d;
        end
    end

    // ---------------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------------
    assign S_SPI_MISO_OE = S_ENABLE & ~cs_s;
    assign S_SPI_MISO    = S_SPI_MISO_OE & miso_q;
    // Gated with S_ENABLE so a write is never acknowledged while disabled.
    assign S_WREADY      = wready_q & S_ENABLE;
    assign S_RCHAR       = rchar_q;
    assign S_RCHAR_DONE  = done_q;
    assign S_UNDERRUN    = underrun_q;

endmodule

// File: tb/tb_spi_slave_trx_char.sv
// ---------------------------------------------------------------------------
// tb_spi_slave_trx_char
//
// Directed bench for spi_slave_trx_char. A behavioural SPI master drives the
// pins with SCK half-periods of H system clocks and captures MISO at its own
// sample edges. Table vectors cover the four modes, both bit orders and the
// short-length rounding; hand sequences cover back-to-back characters with
// an underrun, a CS_N abort, enable handling and reset mid-character.
// ---------------------------------------------------------------------------
module tb_spi_slave_trx_char;

    localparam int H = 6;

    logic        S_SYSCLK;
    logic        S_RESETN;
    logic        S_ENABLE;
    logic        S_CPOL;
    logic        S_CPHA;
    logic        S_REV;
    logic [3:0]  S_CHAR_LEN;
    logic        S_SPI_SCK;
    logic        S_SPI_CS_N;
    logic        S_SPI_MOSI;
    logic        S_SPI_MISO;
    logic        S_SPI_MISO_OE;
    logic [15:0] S_WCHAR;
    logic        S_WVALID;
    logic        S_WREADY;
    logic [15:0] S_RCHAR;
    logic        S_RCHAR_DONE;
    logic        S_UNDERRUN;

    int total = 0;
    int bad   = 0;
    int done_cnt = 0;
    int und_cnt  = 0;

    spi_slave_trx_char #(.CHAR_LEN_MAX(16), .SYNC_STAGES(2)) dut (
        .S_SYSCLK      (S_SYSCLK),
        .S_RESETN      (S_RESETN),
        .S_ENABLE      (S_ENABLE),
        .S_CPOL        (S_CPOL),
        .S_CPHA        (S_CPHA),
        .S_REV         (S_REV),
        .S_CHAR_LEN    (S_CHAR_LEN),
        .S_SPI_SCK     (S_SPI_SCK),
        .S_SPI_CS_N    (S_SPI_CS_N),
        .S_SPI_MOSI    (S_SPI_MOSI),
        .S_SPI_MISO    (S_SPI_MISO),
        .S_SPI_MISO_OE (S_SPI_MISO_OE),
        .S_WCHAR       (S_WCHAR),
        .S_WVALID      (S_WVALID),
        .S_WREADY      (S_WREADY),
        .S_RCHAR       (S_RCHAR),
        .S_RCHAR_DONE  (S_RCHAR_DONE),
        .S_UNDERRUN    (S_UNDERRUN)
    );

    initial S_SYSCLK = 1'b0;
    always #5 S_SYSCLK = ~S_SYSCLK;

    // Strobe counters, sampled on the inactive edge.
    always @(negedge S_SYSCLK) begin
        if (S_RCHAR_DONE === 1'b1) done_cnt++;
        if (S_UNDERRUN === 1'b1)   und_cnt++;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        cpol;
        logic        cpha;
        logic        rev;
        logic [3:0]  char_len;
        int          nbits;
        logic [15:0] tx;
        logic [15:0] mosi;
        logic [15:0] exp_miso;
        logic [15:0] exp_rchar;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge S_SYSCLK);
        #1;
    endtask

    task automatic write_word(input logic [15:0] w);
        S_WCHAR  = w;
        S_WVALID = 1'b1;
        for (int k = 0; k < 50 && !S_WREADY; k++) wait_cyc(1);
        chk("wready_wait", {31'd0, S_WREADY}, 32'd1);
        wait_cyc(1);
        S_WVALID = 1'b0;
    endtask

    task automatic frame_begin();
        S_SPI_SCK = S_CPOL;
        wait_cyc(4);
        S_SPI_CS_N = 1'b0;
    endtask

    task automatic frame_end();
        wait_cyc(H);
        S_SPI_CS_N = 1'b1;
        wait_cyc(8);
    endtask

    // Clock nclk bits of an nbits-wide character; MISO bits land in got.
    task automatic xfer_char(input logic [15:0] tx, input int nbits, input int nclk,
                             output logic [15:0] got);
        int idx;
        got = '0;
        for (int i = 0; i < nclk; i++) begin
            idx = S_REV ? (nbits - 1 - i) : i;
            if (!S_CPHA) begin
                S_SPI_MOSI = tx[idx];
                wait_cyc(H);
                S_SPI_SCK = ~S_CPOL;
                got[idx]  = S_SPI_MISO;
                wait_cyc(H);
                S_SPI_SCK = S_CPOL;
            end else begin
                wait_cyc(H);
                S_SPI_SCK  = ~S_CPOL;
                S_SPI_MOSI = tx[idx];
                wait_cyc(H);
                S_SPI_SCK = S_CPOL;
                got[idx]  = S_SPI_MISO;
            end
        end
    endtask

    initial begin
        vec_t        v;
        logic [15:0] got;
        logic [15:0] got2;
        logic [15:0] got3;
        int          d0;
        int          u0;

        //            cpol  cpha  rev   len    nb  tx        mosi      exp_miso  exp_rchar
        vecs[0] = '{1'b0, 1'b0, 1'b1, 4'd7,  8,  16'h00A5, 16'h003C, 16'h00A5, 16'h003C};
        vecs[1] = '{1'b0, 1'b1, 1'b0, 4'd15, 16, 16'h1234, 16'hBEEF, 16'h1234, 16'hBEEF};
        vecs[2] = '{1'b1, 1'b0, 1'b0, 4'd15, 16, 16'h1234, 16'hBEEF, 16'h1234, 16'hBEEF};
        vecs[3] = '{1'b1, 1'b1, 1'b0, 4'd15, 16, 16'h1234, 16'hBEEF, 16'h1234, 16'hBEEF};
        vecs[4] = '{1'b0, 1'b0, 1'b1, 4'd3,  4,  16'h0006, 16'h000B, 16'h0006, 16'h000B};
        vecs[5] = '{1'b0, 1'b0, 1'b1, 4'd1,  4,  16'h0009, 16'h000B, 16'h0009, 16'h000B};
        vecs[6] = '{1'b1, 1'b1, 1'b1, 4'd11, 12, 16'h0ABC, 16'h05A3, 16'h0ABC, 16'h05A3};

        S_RESETN   = 1'b0;
        S_ENABLE   = 1'b1;
        S_CPOL     = 1'b0;
        S_CPHA     = 1'b0;
        S_REV      = 1'b1;
        S_CHAR_LEN = 4'd7;
        S_SPI_SCK  = 1'b0;
        S_SPI_CS_N = 1'b1;
        S_SPI_MOSI = 1'b0;
        S_WCHAR    = '0;
        S_WVALID   = 1'b0;

        // Reset state
        wait_cyc(3);
        chk("rst_miso",     {31'd0, S_SPI_MISO},    32'd0);
        chk("rst_oe",       {31'd0, S_SPI_MISO_OE}, 32'd0);
        chk("rst_wready",   {31'd0, S_WREADY},      32'd0);
        chk("rst_rchar",    {16'd0, S_RCHAR},       32'd0);
        chk("rst_done",     {31'd0, S_RCHAR_DONE},  32'd0);
        chk("rst_underrun", {31'd0, S_UNDERRUN},    32'd0);
        S_RESETN = 1'b1;
        chk("rel_wready_0", {31'd0, S_WREADY}, 32'd0);
        wait_cyc(1);
        chk("rel_wready_1", {31'd0, S_WREADY}, 32'd1);
        $display("reset: wready=%0d rchar=%h", S_WREADY, S_RCHAR);

        // Table vectors: one character per frame. A spare word is written
        // after the first LOAD so the LOAD that follows the last sample
        // does not underrun; that word is dropped when CS_N rises.
        for (int i = 0; i < 7; i++) begin
            v = vecs[i];
            S_CPOL     = v.cpol;
            S_CPHA     = v.cpha;
            S_REV      = v.rev;
            S_CHAR_LEN = v.char_len;
            wait_cyc(2);
            write_word(v.tx);
            d0 = done_cnt;
            u0 = und_cnt;
            frame_begin();
            write_word(16'hFFFF);
            xfer_char(v.mosi, v.nbits, v.nbits, got);
            frame_end();
            chk($sformatf("v%0d_miso", i),     {16'd0, got},     {16'd0, v.exp_miso});
            chk($sformatf("v%0d_rchar", i),    {16'd0, S_RCHAR}, {16'd0, v.exp_rchar});
            chk($sformatf("v%0d_done", i),     done_cnt - d0,    32'd1);
            chk($sformatf("v%0d_underrun", i), und_cnt - u0,     32'd0);
            chk($sformatf("v%0d_wready", i),   {31'd0, S_WREADY}, 32'd1);
            chk($sformatf("v%0d_oe_idle", i),  {31'd0, S_SPI_MISO_OE}, 32'd0);
            $display("vec %0d: cpol=%0d cpha=%0d rev=%0d len=%0d miso=%h rchar=%h",
                     i, v.cpol, v.cpha, v.rev, v.nbits, got, S_RCHAR);
        end

        // Three back-to-back 8-bit characters; the second word arrives
        // after the second character has already been loaded.
        S_CPOL = 1'b0; S_CPHA = 1'b0; S_REV = 1'b1; S_CHAR_LEN = 4'd7;
        wait_cyc(2);
        write_word(16'h0011);
        d0 = done_cnt;
        u0 = und_cnt;
        frame_begin();
        xfer_char(16'h0081, 8, 8, got);
        chk("b2b_rchar1", {16'd0, S_RCHAR}, 32'h0081);
        write_word(16'h0033);
        xfer_char(16'h0042, 8, 8, got2);
        chk("b2b_rchar2", {16'd0, S_RCHAR}, 32'h0042);
        write_word(16'h0044);
        xfer_char(16'h00C5, 8, 8, got3);
        frame_end();
        chk("b2b_miso1",    {16'd0, got},     32'h0011);
        chk("b2b_miso2",    {16'd0, got2},    32'h00FF);
        chk("b2b_miso3",    {16'd0, got3},    32'h0033);
        chk("b2b_underrun", und_cnt - u0,     32'd1);
        chk("b2b_done",     done_cnt - d0,    32'd3);
        chk("b2b_rchar3",   {16'd0, S_RCHAR}, 32'h00C5);
        $display("b2b: miso=%h,%h,%h underruns=%0d dones=%0d",
                 got, got2, got3, und_cnt - u0, done_cnt - d0);

        // CS_N rises after 5 of 8 bits: nothing reported, next frame clean.
        write_word(16'h0077);
        d0 = done_cnt;
        frame_begin();
        xfer_char(16'h0012, 8, 5, got);
        frame_end();
        chk("abort_done",   done_cnt - d0,     32'd0);
        chk("abort_rchar",  {16'd0, S_RCHAR},  32'h00C5);
        chk("abort_wready", {31'd0, S_WREADY}, 32'd1);
        write_word(16'h00C3);
        d0 = done_cnt;
        frame_begin();
        write_word(16'hFFFF);
        xfer_char(16'h005A, 8, 8, got);
        frame_end();
        chk("after_abort_miso",  {16'd0, got},     32'h00C3);
        chk("after_abort_rchar", {16'd0, S_RCHAR}, 32'h005A);
        chk("after_abort_done",  done_cnt - d0,    32'd1);
        $display("abort: rchar=%h miso_next=%h", S_RCHAR, got);

        // Enable low empties the holding register and holds WREADY low.
        write_word(16'h0099);
        chk("en_full_wready", {31'd0, S_WREADY}, 32'd0);
        S_ENABLE = 1'b0;
        wait_cyc(2);
        chk("en_low_wready", {31'd0, S_WREADY}, 32'd0);
        S_SPI_CS_N = 1'b0;
        wait_cyc(4);
        chk("en_low_oe", {31'd0, S_SPI_MISO_OE}, 32'd0);
        S_SPI_CS_N = 1'b1;
        wait_cyc(4);
        S_ENABLE = 1'b1;
        wait_cyc(2);
        chk("en_high_wready", {31'd0, S_WREADY}, 32'd1);
        $display("enable: wready=%0d", S_WREADY);

        // Reset asserted mid-character.
        write_word(16'h0066);
        frame_begin();
        xfer_char(16'h000F, 8, 3, got);
        chk("mid_oe_before", {31'd0, S_SPI_MISO_OE}, 32'd1);
        S_RESETN = 1'b0;
        #1;
        chk("mid_rst_miso",     {31'd0, S_SPI_MISO},    32'd0);
        chk("mid_rst_oe",       {31'd0, S_SPI_MISO_OE}, 32'd0);
        chk("mid_rst_wready",   {31'd0, S_WREADY},      32'd0);
        chk("mid_rst_rchar",    {16'd0, S_RCHAR},       32'd0);
        chk("mid_rst_done",     {31'd0, S_RCHAR_DONE},  32'd0);
        chk("mid_rst_underrun", {31'd0, S_UNDERRUN},    32'd0);
        S_SPI_CS_N = 1'b1;
        S_SPI_SCK  = S_CPOL;
        wait_cyc(4);
        S_RESETN = 1'b1;
        chk("mid_rel_wready_0", {31'd0, S_WREADY}, 32'd0);
        wait_cyc(1);
        chk("mid_rel_wready_1", {31'd0, S_WREADY}, 32'd1);
        $display("reset mid-char: rchar=%h wready=%0d", S_RCHAR, S_WREADY);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/spi_slave_trx_char.md
# spi_slave_trx_char

SPI target-side character transceiver: the responder at the opposite end of the link from the SPI master character engine. All logic runs in the S_SYSCLK domain. The block oversamples the externally driven SCK, CS_N and MOSI. It shifts out one transmit character per CS_N-framed character time and returns each received character with a one-cycle done strobe. It sits between the SPI pins and the register/FIFO layer of the SPI slave controller.

## Interface
- CHAR_LEN_MAX, 16, widest character in bits; sets the S_WCHAR and S_RCHAR width.
- SYNC_STAGES, 2, synchronizer depth on SCK, CS_N and MOSI; legal values are 2 or 3.
- S_SYSCLK  in  1  platform clock.
- S_RESETN  in  1  reset, asynchronous, active-low.
- S_ENABLE  in  1  block enable; low forces IDLE and empties the holding register.
- S_CPOL  in  1  SCK idle level.
- S_CPHA  in  1  0: sample on leading edge; 1: sample on trailing edge.
- S_REV  in  1  1: MSB first; 0: LSB first.
- S_CHAR_LEN  in  4  character length = S_CHAR_LEN+1 bits; values 0–2 are treated as 4 bits.
- S_SPI_SCK  in  1  serial clock from the master.
- S_SPI_CS_N  in  1  chip select, active-low.
- S_SPI_MOSI  in  1  serial data in.
- S_SPI_MISO  out  1  serial data out.
- S_SPI_MISO_OE  out  1  MISO pad output enable.
- S_WCHAR  in  CHAR_LEN_MAX  transmit character, right-aligned.
- S_WVALID  in  1  S_WCHAR valid.
- S_WREADY  out  1  transmit holding register empty.
- S_RCHAR  out  CHAR_LEN_MAX  last received character, right-aligned, upper bits 0.
- S_RCHAR_DONE  out  1  one-cycle strobe: S_RCHAR updated.
- S_UNDERRUN  out  1  one-cycle strobe: character started with an empty holding register.

## Operation
- **Input synchronization:** SCK, CS_N and MOSI each pass through SYNC_STAGES flops. Edges are detected on the synced SCK by comparing it with a one-cycle-delayed copy.
- **Edge definitions:**
  - Leading edge = synced SCK leaves S_CPOL. Trailing edge = synced SCK returns to S_CPOL.
  - Sample edge = leading edge when CPHA=0, trailing edge when CPHA=1.
  - Shift edge = the opposite edge.
- **States:**
  - IDLE: synced CS_N high, or S_ENABLE low.
  - LOAD: one cycle, entered on a CS_N fall or a character boundary. Moves the holding register into the tx shift register and resets the bit counter to len-1.
  - SHIFT: counts samples.
- **Transitions:**
  - IDLE → LOAD on the synced CS_N falling edge.
  - LOAD → SHIFT unconditionally.
  - SHIFT → LOAD after the len-th sample edge when CS_N is still low.
  - Any state → IDLE on CS_N high or S_ENABLE low.
- **First bit (CPHA=0):** driven in LOAD, before the first SCK edge. Subsequent bits are driven on shift edges.
- **First bit (CPHA=1):** driven on the first shift edge, which is the leading edge. Shift edges are ignored before the first one of each character and after the last sample of each character.
- **Bit order:** when MSB first, the first bit is S_WCHAR[len-1]; when LSB first, it is S_WCHAR[0].
- **Receive:** on each sample edge, synced MOSI is shifted into the rx register. After the len-th sample, S_RCHAR receives the bits right-aligned in the selected order, and S_RCHAR_DONE pulses in the same cycle.
- **Holding register handshake:**
  - S_WREADY=1 when the register is empty. The register is loaded on S_WVALID&S_WREADY.
  - LOAD empties the register, and S_WREADY rises the next cycle.
  - If the register is empty at LOAD, the shift register is loaded with all ones and S_UNDERRUN pulses.
- **Output enable:** S_SPI_MISO_OE = S_ENABLE & ~synced CS_N. S_SPI_MISO = 0 while the output enable is low.
- **CS_N rising mid-character:** the partial character is discarded; no DONE and no S_RCHAR change. A holding-register word already moved to the shift register is lost. The bit counter is reset.
- **S_ENABLE low:** same abort behaviour as a mid-character CS_N rise. In addition, the holding register is emptied and S_WREADY is held 0.
- **Simultaneous S_WVALID handshake and LOAD in one cycle:** LOAD takes the old register contents (or underruns if the register was empty). The new word is written into the register.

## Timing
- **Reset values:** S_SPI_MISO 0, S_SPI_MISO_OE 0, S_WREADY 0, S_RCHAR 0, S_RCHAR_DONE 0, S_UNDERRUN 0.
- **S_WREADY after reset:** rises 1 cycle after reset release when S_ENABLE=1.
- **Input latency:** a pin edge becomes visible internally SYNC_STAGES cycles later, and the edge is detected 1 cycle after that.
- **MISO latency:** MISO changes SYNC_STAGES+1 cycles after the SCK shift edge at the pin.
- **DONE latency:** S_RCHAR_DONE fires SYNC_STAGES+1 cycles after the final sample edge at the pin.
- **CPHA=0 first bit:** valid SYNC_STAGES+2 cycles after the CS_N fall at the pin.
- **SCK limit:** each SCK high and low phase must be ≥ SYNC_STAGES+2 S_SYSCLK cycles. The minimum CS_N-fall-to-first-edge interval has the same limit.
- **Back-to-back characters:** supported with no gap in SCK. LOAD completes before the first shift edge of the next character.

## Test plan
- Mode 0, MSB first, len 8, S_WCHAR=0xA5 preloaded, master sends 0x3C → MISO carries 0xA5 MSB first; S_RCHAR=0x003C; one DONE pulse.
- Modes 1/2/3, LSB first, len 16, tx 0x1234, rx 0xBEEF → per mode: correct MISO bitstream, S_RCHAR=0xBEEF, exactly one DONE.
- Three back-to-back 8-bit characters under one CS_N, second word written late → chars 1 and 3 sent correctly; char 2 sends 0xFF and S_UNDERRUN pulses once.
- CS_N raised after 5 of 8 bits → no DONE, S_RCHAR unchanged; next frame receives a full character correctly.
- Reset asserted mid-character → all outputs take their reset values immediately; S_WREADY=1 one cycle after release.
- len 4 (S_CHAR_LEN=3) and S_CHAR_LEN=1, rx 0xB → both yield S_RCHAR=0x000B after 4 SCK cycles.
